// File: rtl/imem_stream_loader.sv
// Purpose : loads CPU instruction memory from a framed byte stream
//           (LEN_HI, LEN_LO, 4*N big-endian data bytes, XOR checksum) and
//           holds the CPU in reset until a frame checks good.
// Latency : one registered write cycle after each word's 4th byte.
// Backpressure: in_ready=1 in every frame state (1 byte/cycle), 0 when
//           idle/done/err; in_valid=0 stalls indefinitely with state held.
// Ports   : clk/rst (async active-low); start (level); in_valid/in_data/
//           in_ready byte stream; imem_we/imem_addr/imem_wdata memory
//           write port; cpu_rst, load_pc, busy, done, err status.
module imem_stream_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] TEXT_BASE  = 32'h0000_3000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic [31:0]           load_pc,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t                state, state_nxt;
  logic [15:0]           n_words;
  logic [1:0]            byte_idx;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [7:0]            acc;
  logic [23:0]           asm_q;     // first three bytes of the word in flight

  // Length decode happens in the LEN_LO cycle, with the low byte still on
  // the input bus.  17-bit compare so a full-capacity frame is legal.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  logic [15:0] len_full;
  logic        len_zero;
  logic        len_over;
  logic        last_word;

  assign len_full  = {n_words[15:8], in_data};
  assign len_zero  = (len_full == 16'd0);
  assign len_over  = ({1'b0, len_full} > CAPACITY);
  // word_idx still holds the index of the word being assembled here
  assign last_word = (17'(word_idx) == ({1'b0, n_words} - 17'd1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (len_zero)      state_nxt = S_CHK;
          else if (len_over) state_nxt = S_ERR;
          else               state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid && byte_idx == 2'd3 && last_word) state_nxt = S_CHK;
      end
      S_CHK: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (in_data == acc) ? S_DONE : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      n_words    <= '0;
      byte_idx   <= '0;
      word_idx   <= '0;
      acc        <= '0;
      asm_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      load_pc    <= TEXT_BASE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state   <= state_nxt;
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            done     <= 1'b0;
            err      <= 1'b0;
            acc      <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            cpu_rst  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (in_valid) begin
            n_words[15:8] <= in_data;
            acc           <= acc ^ in_data;
          end
        end
        S_LEN_LO: begin
          if (in_valid) begin
            n_words[7:0] <= in_data;
            acc          <= acc ^ in_data;
            if (!len_zero && len_over) begin
              err  <= 1'b1;
              busy <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (in_valid) begin
            acc      <= acc ^ in_data;
            asm_q    <= {asm_q[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_idx;
              imem_wdata <= {asm_q, in_data};
              load_pc    <= TEXT_BASE + (32'(word_idx) << 2);
              word_idx   <= word_idx + 1'b1;
            end
          end
        end
        S_CHK: begin
          if (in_valid) begin
            busy <= 1'b0;
            if (in_data == acc) begin
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
